// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage that sits directly after pc_counter. It takes the
// registered PC, issues an instruction-memory request using a req/ack
// handshake, and loads the IF/ID pipeline register. It also returns the next
// PC to pc_counter. pc_counter reloads on every cycle, so this block freezes
// the PC by driving next_addr = pc_in.
//
// Ports:
//   clk              clock; all state changes on posedge
//   reset            synchronous, active-high
//   pc_in            current PC from pc_counter
//   next_addr        next PC to pc_counter (combinational)
//   imem_req         instruction-memory fetch request
//   imem_addr        word-aligned fetch address derived from pc_in
//   imem_ack         memory returns imem_rdata this cycle
//   imem_rdata       instruction word from memory
//   stall            hazard unit: hold IF/ID and PC
//   redirect_valid   taken branch/jump: flush fetch
//   redirect_target  new PC for a redirect
//   ifid_valid       IF/ID holds a real instruction
//   ifid_instr       fetched instruction
//   ifid_pc          PC of ifid_instr
//   ifid_pc_plus4    ifid_pc + 4 (modulo 2^32)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] next_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4
);

    // FETCH : request issued this cycle
    // WAIT  : request outstanding, no ack yet
    // HOLD  : word parked in the skid buffer while ID is stalled
    // DRAIN : one stale ack still owed to us after a redirect
    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        IFID_KEEP,
        IFID_BUBBLE,
        IFID_LOAD
    } ifid_op_t;

    state_t      state;
    state_t      state_nxt;
    ifid_op_t    ifid_op;
    logic        skid_load;
    logic [31:0] skid;
    logic [31:0] pc_plus4;
    logic        in_flight;
    logic        mem_deliver;
    logic        deliver;
    logic [31:0] deliver_instr;

    // Natural 32-bit wrap: 0xFFFFFFFC + 4 = 0.
    assign pc_plus4      = pc_in + 32'd4;
    assign imem_addr     = {pc_in[31:2], 2'b00};
    assign in_flight     = (state == S_FETCH) || (state == S_WAIT);
    assign mem_deliver   = in_flight && imem_ack;
    // A word parked in HOLD is delivered from the skid buffer. No memory
    // request is made for it.
    assign deliver       = mem_deliver || (state == S_HOLD);
    assign deliver_instr = (state == S_HOLD) ? skid : imem_rdata;
    assign imem_req      = !reset && (state != S_HOLD);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        next_addr = pc_in;
        ifid_op   = IFID_KEEP;
        skid_load = 1'b0;

        if (reset) begin
            next_addr = RESET_VECTOR;
        end else if (redirect_valid) begin
            next_addr = {redirect_target[31:2], 2'b00};
            ifid_op   = IFID_BUBBLE;
            // If a request is still in flight, its ack will arrive later and
            // must be absorbed in DRAIN. This covers a re-redirect in DRAIN.
            // A skid word is abandoned by leaving HOLD.
            state_nxt = (imem_req && !imem_ack) ? S_DRAIN : S_FETCH;
        end else if (state == S_DRAIN) begin
            // pc_counter already holds the redirect target. The stale ack is
            // dropped and IF/ID sees bubbles until it arrives.
            ifid_op = IFID_BUBBLE;
            if (imem_ack) begin
                state_nxt = S_FETCH;
            end
        end else if (stall) begin
            if (mem_deliver) begin
                skid_load = 1'b1;
                state_nxt = S_HOLD;
            end else if (in_flight) begin
                state_nxt = S_WAIT;
            end
        end else if (deliver) begin
            ifid_op   = IFID_LOAD;
            next_addr = pc_plus4;
            state_nxt = S_FETCH;
        end else begin
            ifid_op   = IFID_BUBBLE;
            state_nxt = S_WAIT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_FETCH;
            skid          <= '0;
            ifid_valid    <= 1'b0;
            ifid_instr    <= NOP_INSTR;
            ifid_pc       <= '0;
            ifid_pc_plus4 <= '0;
        end else begin
            state <= state_nxt;
            if (skid_load) begin
                skid <= imem_rdata;
            end
            case (ifid_op)
                IFID_LOAD: begin
                    ifid_valid    <= 1'b1;
                    ifid_instr    <= deliver_instr;
                    ifid_pc       <= pc_in;
                    ifid_pc_plus4 <= pc_plus4;
                end
                IFID_BUBBLE: begin
                    ifid_valid <= 1'b0;
                    ifid_instr <= NOP_INSTR;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly downstream of pc_counter.
- Takes the registered PC (current) and issues an instruction-memory request with a req/ack handshake.
- Computes next_addr, which it returns to pc_counter, and loads the IF/ID pipeline register.
- pc_counter reloads every cycle, so this block freezes the PC by driving next_addr = pc_in.

Parameters:
RESET_VECTOR, 32'h00003000, PC value the stage treats as architectural reset PC
NOP_INSTR, 32'h00000000, instruction word placed in IF/ID on a bubble

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high
pc_in  in  32  current PC from pc_counter
next_addr  out  32  next PC to pc_counter (combinational)
imem_req  out  1  fetch request
imem_addr  out  32  fetch address = {pc_in[31:2],2'b00}
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word
stall  in  1  hazard unit: hold IF/ID and PC
redirect_valid  in  1  branch/jump taken, flush fetch
redirect_target  in  32  new PC
ifid_valid  out  1  IF/ID holds a real instruction
ifid_instr  out  32  fetched instruction
ifid_pc  out  32  PC of ifid_instr
ifid_pc_plus4  out  32  ifid_pc+4

Behaviour:
Reset (synchronous, while reset=1):
- state<=FETCH, ifid_valid<=0, ifid_instr<=NOP_INSTR, ifid_pc<=0, ifid_pc_plus4<=0, skid buffer cleared.
- Combinationally imem_req=0 and next_addr=RESET_VECTOR.
- Reset asserted mid-operation discards any outstanding request, skid contents and pending redirect.

States:
- FETCH: request issued.
- WAIT: request outstanding, no ack yet.
- HOLD: instruction captured in skid buffer while ID stalled.
- DRAIN: discard one stale ack after a redirect.

imem_req:
- 1 in FETCH, WAIT and DRAIN; 0 in HOLD and during reset.
- imem_addr is held stable while imem_req=1 and ack=0.
- Ack latency is unbounded, 0 or more wait cycles; an ack in the same cycle as the request is legal.

"deliver" is true when either:
- state is FETCH or WAIT and imem_ack=1, with instruction = imem_rdata; or
- state is HOLD, with instruction = skid.

Priority per cycle, reset > redirect > stall > normal:
1. redirect_valid=1 (overrides stall):
   - next_addr={redirect_target[31:2],2'b00}.
   - IF/ID: valid<=0, instr<=NOP_INSTR.
   - Skid is dropped.
   - If a request is outstanding without ack this cycle (FETCH/WAIT with ack=0), go to DRAIN; otherwise go to FETCH.
2. stall=1:
   - IF/ID holds; next_addr=pc_in.
   - If deliver from memory: skid<=imem_rdata, go to HOLD.
   - HOLD stays HOLD. FETCH/WAIT without ack go to WAIT.
3. Normal, no stall:
   - If deliver: IF/ID <= {1, instruction, pc_in, pc_in+4}; next_addr=pc_in+4; go to FETCH.
   - Else (FETCH/WAIT without ack): IF/ID valid<=0, instr<=NOP_INSTR; next_addr=pc_in; go to WAIT.

DRAIN:
- next_addr equals the latched redirect target, which is held in pc via pc_counter, so next_addr=pc_in.
- IF/ID gets bubbles.
- On imem_ack: data discarded, go to FETCH. A new redirect in DRAIN reloads next_addr and stays in DRAIN.

Arithmetic and boundaries:
- pc+4 is modulo 2^32: 32'hFFFFFFFC+4 = 0, no flag.
- ifid_pc_plus4 uses the same wrap.
- Exactly one instruction is delivered per ack, and never duplicated. A stall released in HOLD delivers the skid word and issues no memory request that cycle.

Test Plan:
- Reset: reset=1 two cycles with pc_counter attached -> pc_in=0x3000, imem_req=0, ifid_valid=0. Release with zero-wait ack -> ifid sees 0x3000, 0x3004, 0x3008 on consecutive cycles, ifid_pc_plus4=0x3004 for the first.
- Wait states: ack 2 cycles late -> imem_addr=0x3000 held for 3 cycles, next_addr=0x3000, two bubbles (ifid_valid=0), then ifid_pc=0x3000.
- Stall: stall=1 in the cycle ack returns word 0xAABBCCDD at 0x3004 -> IF/ID unchanged, state HOLD, PC frozen. Stall low -> ifid_instr=0xAABBCCDD, ifid_pc=0x3004, next_addr=0x3008, no extra imem_req.
- Redirect in WAIT: redirect_valid with target 0x4001 while awaiting ack -> next_addr=0x4000, DRAIN. Stale ack data is not delivered. Next request address is 0x4000.
- Redirect with stall=1 and HOLD occupied -> skid dropped, ifid_valid=0, next fetch at target.
- Wrap: pc_in=0xFFFFFFFC, ack -> next_addr=0, ifid_pc_plus4=0.
